// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg -- shared types for the interrupt controller.
//   NUM_IRQ      number of interrupt sources
//   irq_state_t  controller FSM state
//   irq_cause_t  one-hot cause / per-source bit vector
//   lowest_one() priority pick, bit 0 highest
package irq_ctrl_pkg;

  localparam int NUM_IRQ = 4;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_t;

  typedef logic [NUM_IRQ-1:0] irq_cause_t;

  // One-hot of the lowest set bit; zero in -> zero out.
  function automatic irq_cause_t lowest_one(input irq_cause_t v);
    irq_cause_t r;
    r = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect -- per-source rising-edge detector.
//   clock  in   sole clock
//   reset  in   synchronous active-high reset
//   din    in   raw request line
//   pulse  out  one-cycle pulse on a qualified 0->1 transition
// Macro IRQ_CTRL_SYNC_EN: inserts a 2-flop synchroniser ahead of the
// edge history.
module irq_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic pulse
);

`ifdef IRQ_CTRL_SYNC_EN
  localparam int STAGES = 2;
  logic [1:0] sync_q;
  logic       din_s;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], din};
  end
  assign din_s = sync_q[1];
`else
  localparam int STAGES = 0;
  logic din_s;
  assign din_s = din;
`endif

  logic              hist;
  // vld_pipe fills with ones after reset; the top bit marks that hist
  // holds a genuine sample of src rather than its reset value, so a line
  // held high through reset is not mistaken for a fresh edge.
  logic [STAGES:0]   vld_pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      hist     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      hist        <= din_s;
      vld_pipe[0] <= 1'b1;
      for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  assign pulse = din_s & ~hist & vld_pipe[STAGES];

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl -- prioritised interrupt controller with a two-state
// request/acknowledge handshake.
//   clock    in   sole clock
//   reset    in   synchronous active-high reset
//   src      in   [NUM_IRQ] request lines, rising edge = one request
//   ie       in   [NUM_IRQ] per-source enable
//   ack      in   CPU acknowledge pulse
//   irq      out  interrupt request, high exactly while in IRQ_REQ
//   cause    out  [NUM_IRQ] one-hot source taken by the last ack in REQ
//   pending  out  [NUM_IRQ] latched request bits (unmasked view)
// Macro IRQ_CTRL_SYNC_EN: adds a 2-flop synchroniser per source
// (see irq_edge_detect).
module irq_ctrl
  import irq_ctrl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] src,
  input  logic [NUM_IRQ-1:0] ie,
  input  logic               ack,
  output logic               irq,
  output irq_cause_t         cause,
  output logic [NUM_IRQ-1:0] pending
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  irq_cause_t         sel;
  logic [NUM_IRQ-1:0] clr;
  logic               take;
  irq_state_t         state, state_nxt;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_edge
    irq_edge_detect u_edge (
      .clock (clock),
      .reset (reset),
      .din   (src[gi]),
      .pulse (rise[gi])
    );
  end

  assign active = pending & ie;
  assign sel    = lowest_one(active);

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IRQ_IDLE;
    else       state <= state_nxt;
  end

  // next state: REQ drops on any ack, or withdraws when ie masks
  // everything away before the CPU responds
  always_comb begin
    state_nxt = state;
    case (state)
      IRQ_IDLE: if (active != '0)         state_nxt = IRQ_REQ;
      IRQ_REQ:  if (ack || active == '0)  state_nxt = IRQ_IDLE;
      default:                            state_nxt = IRQ_IDLE;
    endcase
  end

  // outputs: an ack only counts in REQ; sel is zero for a spurious ack
  always_comb begin
    take = (state == IRQ_REQ) && ack;
    clr  = take ? sel : '0;
    irq  = (state == IRQ_REQ);
  end

  // set after clear, so a new edge coinciding with the clear wins
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      cause   <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (take) cause <= sel;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ack   = 1'b0;
  logic [3:0] src   = '0;
  logic [3:0] ie    = '0;
  logic       irq;
  logic [3:0] cause;
  logic [3:0] pending;

  always #5 clock = ~clock;

  irq_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .src     (src),
    .ie      (ie),
    .ack     (ack),
    .irq     (irq),
    .cause   (cause),
    .pending (pending)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Tracks the requirement rules directly: a set of latched requests,
  // whether the CPU is currently being asked, and the last taken cause.
  bit       m_req;
  bit [3:0] m_pend, m_cause, m_prev;
  bit [3:0] m_pipe [0:1];
  int       m_since;

  task automatic model_step(input bit r, input bit [3:0] s, input bit [3:0] e,
                            input bit a);
    bit [3:0] cur, edges, act;
    int pick;
    if (r) begin
      m_req = 0; m_pend = '0; m_cause = '0; m_prev = '0;
      m_pipe[0] = '0; m_pipe[1] = '0; m_since = 0;
      return;
    end
    if (D == 0) cur = s;
    else        cur = m_pipe[1];
    edges = (m_since >= D + 1) ? (cur & ~m_prev) : 4'b0000;
    act   = m_pend & e;
    if (m_req && a) begin
      pick = -1;
      for (int i = 0; i < 4; i++) if (act[i] && pick < 0) pick = i;
      m_cause = '0;
      if (pick >= 0) begin
        m_cause[pick] = 1'b1;
        m_pend[pick]  = 1'b0;
      end
      m_req = 0;
    end else begin
      m_req = (act != 0);
    end
    m_pend    = m_pend | edges;
    m_prev    = cur;
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = s;
    m_since++;
  endtask

  task automatic check(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // drive one cycle, advance model, sample 1 time unit after the edge
  task automatic cyc(input bit r, input bit [3:0] s, input bit [3:0] e,
                     input bit a);
    reset = r; src = s; ie = e; ack = a;
    model_step(r, s, e, a);
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       r;
    bit [3:0] s, e;
    bit       a;
    bit       x_irq;
    bit [3:0] x_cause, x_pend;
  } vec_t;

  function automatic vec_t mk(bit r, bit [3:0] s, bit [3:0] e, bit a,
                              bit xi, bit [3:0] xc, bit [3:0] xp);
    vec_t v;
    v.r = r; v.s = s; v.e = e; v.a = a;
    v.x_irq = xi; v.x_cause = xc; v.x_pend = xp;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
`ifndef IRQ_CTRL_SYNC_EN
    //           r  src    ie     ack irq cause   pending
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0)); // reset state
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h1, 4'hF, 0, 0, 4'h0, 4'h1)); // single edge
    tbl.push_back(mk(0, 4'h1, 4'hF, 0, 1, 4'h0, 4'h1)); // irq next
    tbl.push_back(mk(0, 4'h1, 4'hF, 1, 0, 4'h1, 4'h0)); // ack
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h1, 4'h0));
    tbl.push_back(mk(0, 4'h6, 4'hF, 0, 0, 4'h1, 4'h6)); // two at once
    tbl.push_back(mk(0, 4'h6, 4'hF, 0, 1, 4'h1, 4'h6));
    tbl.push_back(mk(0, 4'h6, 4'hF, 1, 0, 4'h2, 4'h4)); // bit1 first
    tbl.push_back(mk(0, 4'h6, 4'hF, 0, 1, 4'h2, 4'h4)); // re-raise
    tbl.push_back(mk(0, 4'h6, 4'hF, 1, 0, 4'h4, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h4, 4'h0));
    tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 4'h4, 4'h8)); // masked latch
    tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 4'h4, 4'h8));
    tbl.push_back(mk(0, 4'h8, 4'h8, 0, 1, 4'h4, 4'h8)); // unmask
    tbl.push_back(mk(0, 4'h8, 4'h0, 0, 0, 4'h4, 4'h8)); // withdraw
    tbl.push_back(mk(0, 4'h8, 4'h0, 1, 0, 4'h4, 4'h8)); // ack in IDLE
    tbl.push_back(mk(0, 4'h1, 4'h1, 0, 0, 4'h4, 4'h9));
    tbl.push_back(mk(0, 4'h0, 4'h1, 0, 1, 4'h4, 4'h9));
    tbl.push_back(mk(0, 4'h1, 4'h1, 1, 0, 4'h1, 4'h9)); // set beats clear
    tbl.push_back(mk(0, 4'h1, 4'h1, 0, 1, 4'h1, 4'h9));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 0, 4'h0, 4'h0)); // reset mid-REQ
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 4'h0)); // held high
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'h4, 4'hF, 0, 0, 4'h0, 4'h4));
    tbl.push_back(mk(0, 4'h4, 4'hF, 0, 1, 4'h0, 4'h4));
    tbl.push_back(mk(0, 4'h4, 4'hF, 1, 0, 4'h4, 4'h0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 4'h4, 4'h0));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 4'h4, 4'h2));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 1, 4'h4, 4'h2));
    tbl.push_back(mk(0, 4'h2, 4'h0, 1, 0, 4'h0, 4'h2)); // spurious ack
    tbl.push_back(mk(0, 4'h2, 4'h2, 0, 1, 4'h0, 4'h2)); // masked re-req
    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].s, tbl[k].e, tbl[k].a);
      check($sformatf("vec%0d irq", k), {3'b000, irq}, {3'b000, tbl[k].x_irq});
      check($sformatf("vec%0d cause", k), cause, tbl[k].x_cause);
      check($sformatf("vec%0d pending", k), pending, tbl[k].x_pend);
    end
`else
    // synchroniser latency: src[2] edge -> pending 3 edges later
    cyc(1, 4'h0, 4'hF, 0);
    check("sync reset pending", pending, 4'h0);
    repeat (4) cyc(0, 4'h0, 4'hF, 0);
    cyc(0, 4'h4, 4'hF, 0);
    check("sync lat1", pending, 4'h0);
    cyc(0, 4'h4, 4'hF, 0);
    check("sync lat2", pending, 4'h0);
    cyc(0, 4'h4, 4'hF, 0);
    check("sync lat3 pending", pending, 4'h4);
    check("sync lat3 irq", {3'b000, irq}, 4'h0);
    cyc(0, 4'h4, 4'hF, 0);
    check("sync irq rise", {3'b000, irq}, 4'h1);
    cyc(0, 4'h4, 4'hF, 1);
    check("sync ack cause", cause, 4'h4);
`endif

    // ---------------- randomized run against the model ----------------
    cyc(1, 4'h0, 4'h0, 0);
    for (int n = 0; n < 400; n++) begin
      bit       r, a;
      bit [3:0] s, e;
      r = ($urandom_range(0, 39) == 0);
      a = ($urandom_range(0, 2) == 0);
      s = 4'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cyc(r, s, e, a);
      check("rnd irq", {3'b000, irq}, {3'b000, m_req});
      check("rnd cause", cause, m_cause);
      check("rnd pending", pending, m_pend);
    end

    // ---------------- hand sequence: bounded wait for irq ----------------
    begin
      int  b;
      bit  seen;
      cyc(1, 4'h0, 4'hF, 0);
      repeat (D + 2) cyc(0, 4'h0, 4'hF, 0);
      b = $urandom_range(0, 3);
      seen = 0;
      cyc(0, 4'(1 << b), 4'hF, 0);
      for (int t = 0; t < 10 && !seen; t++) begin
        if (irq === 1'b1) seen = 1;
        else cyc(0, 4'(1 << b), 4'hF, 0);
      end
      n_chk++;
      if (!seen) begin
        n_fail++;
        $display("FAIL wait irq: irq never rose within 10 cycles, required 1");
      end
      cyc(0, 4'(1 << b), 4'hF, 1);
      check("wait ack cause", cause, 4'(1 << b));
      check("wait ack pending", pending, 4'h0);
      check("wait ack irq", {3'b000, irq}, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
